// File: rtl/sdram_cmd_responder.sv
// sdram_cmd_responder: BRAM-backed stand-in for an SDRAM controller's client command port
module sdram_cmd_responder #(
    parameter int ADDR_WIDTH        = 22,
    parameter int DEPTH_LOG2        = 12,
    parameter int WRITE_LATENCY     = 2,
    parameter int READ_LATENCY      = 3,
    parameter int READ_BURST_LENGTH = 8,
    parameter int REFRESH_INTERVAL  = 1100,
    parameter int REFRESH_CYCLES    = 9
) (
    input  logic                  clk,
    input  logic                  RESETn,
    input  logic [1:0]            command,
    input  logic [ADDR_WIDTH-1:0] data_address,
    input  logic [15:0]           data_write,
    output logic [15:0]           data_read,
    output logic                  data_read_valid,
    output logic                  data_write_done,
    output logic                  refreshing
);
    localparam int RW = REFRESH_INTERVAL > 1 ? $clog2(REFRESH_INTERVAL) : 1;
    typedef enum logic [2:0] {IDLE, WRITE_WAIT, READ_WAIT, READ_BURST, REFRESH} state_t;
    state_t                state;
    logic [7:0]            cnt;
    logic [DEPTH_LOG2-1:0] ptr;
    logic [15:0]           wdata;
    logic [RW-1:0]         ref_cnt;
    logic                  ref_pending;
    logic                  ref_expire;
    logic                  mem_we;
    logic                  addr_unused;
    logic [15:0]           mem [0:(1<<DEPTH_LOG2)-1];

    assign addr_unused = ^data_address[ADDR_WIDTH-1:DEPTH_LOG2];
    assign ref_expire  = REFRESH_INTERVAL != 0 && ref_cnt == RW'(REFRESH_INTERVAL - 1);
    assign mem_we      = state == WRITE_WAIT && cnt == 8'd0;

    // Memory write port; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (mem_we) mem[ptr] <= wdata;
    end

    // Free-running refresh timer; one pending flag absorbs expiries until IDLE takes it
    always_ff @(posedge clk or negedge RESETn) begin
        if (!RESETn) begin
            ref_cnt     <= '0;
            ref_pending <= 1'b0;
        end else begin
            ref_cnt     <= ref_expire ? '0 : ref_cnt + 1'b1;
            ref_pending <= ref_expire | (ref_pending & (state != IDLE));
        end
    end

    // Command FSM: cnt counts down latency, burst words or refresh stall length
    always_ff @(posedge clk or negedge RESETn) begin
        if (!RESETn) begin
            state           <= IDLE;
            cnt             <= 8'd0;
            ptr             <= '0;
            wdata           <= 16'd0;
            data_read       <= 16'd0;
            data_read_valid <= 1'b0;
            data_write_done <= 1'b0;
            refreshing      <= 1'b0;
        end else begin
            data_write_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (ref_pending) begin
                        state      <= REFRESH;
                        refreshing <= 1'b1;
                        cnt        <= 8'(REFRESH_CYCLES - 1);
                    end else if (command == 2'd1) begin
                        state <= WRITE_WAIT;
                        ptr   <= data_address[DEPTH_LOG2-1:0];
                        wdata <= data_write;
                        cnt   <= 8'(WRITE_LATENCY - 1);
                    end else if (command == 2'd2) begin
                        state <= READ_WAIT;
                        ptr   <= data_address[DEPTH_LOG2-1:0];
                        cnt   <= 8'(READ_LATENCY - 1);
                    end
                end
                WRITE_WAIT: begin
                    if (cnt == 8'd0) begin
                        state           <= IDLE;
                        data_write_done <= 1'b1;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                READ_WAIT: begin
                    if (cnt == 8'd0) begin
                        state           <= READ_BURST;
                        data_read_valid <= 1'b1;
                        data_read       <= mem[ptr];
                        ptr             <= ptr + 1'b1;
                        cnt             <= 8'(READ_BURST_LENGTH - 1);
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                READ_BURST: begin
                    if (cnt == 8'd0) begin
                        state           <= IDLE;
                        data_read_valid <= 1'b0;
                    end else begin
                        data_read <= mem[ptr];
                        ptr       <= ptr + 1'b1;
                        cnt       <= cnt - 8'd1;
                    end
                end
                REFRESH: begin
                    if (cnt == 8'd0) begin
                        state      <= IDLE;
                        refreshing <= 1'b0;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sdram_cmd_responder.sv
// tb_sdram_cmd_responder: random and directed stimulus checked against a schedule-based model
module tb_sdram_cmd_responder;
    localparam int WL = 2;
    localparam int RL = 3;
    localparam int BL = 8;
    localparam int RI = 60;
    localparam int RC = 9;
    localparam int N  = 4096;

    logic        clk = 1'b0;
    logic        RESETn = 1'b0;
    logic [1:0]  command = 2'd0;
    logic [21:0] data_address = 22'd0;
    logic [15:0] data_write = 16'd0;
    logic [15:0] data_read;
    logic        data_read_valid;
    logic        data_write_done;
    logic        refreshing;

    int checks = 0;
    int failures = 0;

    sdram_cmd_responder #(
        .ADDR_WIDTH(22), .DEPTH_LOG2(12), .WRITE_LATENCY(WL), .READ_LATENCY(RL),
        .READ_BURST_LENGTH(BL), .REFRESH_INTERVAL(RI), .REFRESH_CYCLES(RC)
    ) dut (
        .clk(clk), .RESETn(RESETn), .command(command), .data_address(data_address),
        .data_write(data_write), .data_read(data_read), .data_read_valid(data_read_valid),
        .data_write_done(data_write_done), .refreshing(refreshing)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    // Model: each operation is a time window starting at its acceptance edge
    logic [15:0] mm [N];
    bit          mk [N];
    int          m_n, m_free, m_op, m_s, m_a;
    logic [15:0] m_d;
    bit          m_pend;
    bit          e_valid, e_done, e_ref, e_known;
    logic [15:0] e_data;

    initial begin
        forever begin
            @(posedge clk);
            if (!RESETn) begin
                m_n = 0; m_free = 1; m_op = 0; m_pend = 0;
                e_valid = 0; e_done = 0; e_ref = 0; e_data = 16'd0; e_known = 1;
            end else begin
                bit idle;
                m_n++;
                idle = m_n >= m_free;
                if (idle) begin
                    m_s = m_n;
                    if (m_pend) begin
                        m_op = 3; m_free = m_n + RC + 1;
                    end else if (command == 2'd1) begin
                        m_op = 1; m_a = int'(data_address[11:0]); m_d = data_write; m_free = m_n + WL + 1;
                    end else if (command == 2'd2) begin
                        m_op = 2; m_a = int'(data_address[11:0]); m_free = m_n + RL + BL + 1;
                    end else begin
                        m_op = 0;
                    end
                end
                m_pend = (m_n % RI == 0) || (m_pend && !idle);
                e_done = m_op == 1 && m_n == m_s + WL;
                if (e_done) begin
                    mm[m_a] = m_d;
                    mk[m_a] = 1;
                end
                e_ref = m_op == 3 && m_n < m_s + RC;
                e_valid = m_op == 2 && m_n >= m_s + RL && m_n < m_s + RL + BL;
                if (e_valid) begin
                    int idx;
                    idx = (m_a + m_n - m_s - RL) % N;
                    e_data = mm[idx];
                    e_known = mk[idx];
                end
            end
        end
    end

    // Compare every cycle, mid-cycle, plus output exclusivity
    initial begin
        forever begin
            @(negedge clk);
            check("valid", {31'd0, data_read_valid}, {31'd0, RESETn && e_valid});
            check("done", {31'd0, data_write_done}, {31'd0, RESETn && e_done});
            check("refreshing", {31'd0, refreshing}, {31'd0, RESETn && e_ref});
            if (!RESETn || e_known) check("data_read", {16'd0, data_read}, RESETn ? {16'd0, e_data} : 32'd0);
            check("excl_valid_done", {31'd0, data_read_valid & data_write_done}, 32'd0);
            check("excl_refresh", {31'd0, refreshing & (data_read_valid | data_write_done)}, 32'd0);
        end
    end

    int          lat;
    logic [15:0] got [$];

    task automatic do_op(input logic [1:0] c, input logic [11:0] a, input logic [15:0] d);
        bit seen = 0;
        got.delete();
        lat = -1;
        command = c;
        data_address = {10'($urandom), a};
        data_write = d;
        for (int k = 1; k <= 200 && !seen; k++) begin
            @(negedge clk);
            seen = (c == 2'd1) ? data_write_done : data_read_valid;
            if (seen) lat = k - 1;
        end
        command = 2'd0;
        check("op_response", {31'd0, seen}, 32'd1);
        if (c == 2'd2 && seen) begin
            got.push_back(data_read);
            for (int j = 0; j < 300; j++) begin
                @(negedge clk);
                if (!data_read_valid) break;
                got.push_back(data_read);
            end
        end
    endtask

    initial begin
        int pulses, vcnt, rrun, vrun, runs, hold;
        logic [11:0] low;
        repeat (3) @(negedge clk);
        #1 RESETn = 1'b1;
        @(negedge clk);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            pulses += int'(data_read_valid) + int'(data_write_done) + int'(refreshing);
        end
        check("idle_no_pulses", pulses, 0);

        do_op(2'd1, 12'd5, 16'h1234);
        check("write_latency", lat, WL);
        do_op(2'd2, 12'd5, 16'd0);
        check("read_latency", lat, RL);
        check("read_len", got.size(), BL);
        check("read_addr5", {16'd0, got[0]}, 32'h1234);

        for (int i = 0; i < 10; i++) do_op(2'd1, 12'(i), 16'(i));
        do_op(2'd2, 12'd0, 16'd0);
        check("ramp_len", got.size(), 8);
        for (int i = 0; i < 8 && i < got.size(); i++) check("ramp_word", {16'd0, got[i]}, i);
        do_op(2'd2, 12'd8, 16'd0);
        check("ramp8_w0", {16'd0, got[0]}, 8);
        check("ramp8_w1", {16'd0, got[1]}, 9);

        command = 2'd2;
        data_address = {10'h155, 12'd2};
        vcnt = 0;
        for (int i = 0; i < 100 && vcnt < 3; i++) begin
            @(negedge clk);
            if (data_read_valid) begin
                vcnt++;
                command = 2'd0;
            end
        end
        check("third_word", {16'd0, data_read}, 4);
        #1 RESETn = 1'b0;
        @(negedge clk);
        check("reset_kills_valid", {31'd0, data_read_valid}, 0);
        @(negedge clk);
        #1 RESETn = 1'b1;
        vcnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            vcnt += int'(data_read_valid);
        end
        check("no_words_after_reset", vcnt, 0);
        do_op(2'd2, 12'd0, 16'd0);
        check("mem_survives_w0", {16'd0, got[0]}, 0);
        check("mem_survives_w5", {16'd0, got[5]}, 5);

        do_op(2'd1, 12'd4094, 16'hA1A1);
        do_op(2'd1, 12'd4095, 16'hB2B2);
        do_op(2'd1, 12'd0, 16'hC3C3);
        do_op(2'd1, 12'd1, 16'hD4D4);
        do_op(2'd2, 12'd4094, 16'd0);
        check("wrap_w0", {16'd0, got[0]}, 32'hA1A1);
        check("wrap_w1", {16'd0, got[1]}, 32'hB2B2);
        check("wrap_w2", {16'd0, got[2]}, 32'hC3C3);
        check("wrap_w3", {16'd0, got[3]}, 32'hD4D4);

        command = 2'd2;
        data_address = {10'h2AA, 12'd2};
        rrun = 0; vrun = 0; runs = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (refreshing) rrun++;
            else if (rrun != 0) begin
                check("refresh_len", rrun, RC);
                runs++;
                rrun = 0;
            end
            if (data_read_valid) vrun++;
            else if (vrun != 0) begin
                check("burst_len", vrun, BL);
                vrun = 0;
            end
        end
        command = 2'd0;
        check("refresh_seen", {31'd0, runs >= 3}, 1);

        hold = 0;
        for (int i = 0; i < 4000; i++) begin
            if (hold == 0) begin
                int r;
                r = $urandom_range(0, 9);
                command = r < 3 ? 2'd0 : r < 6 ? 2'd1 : r < 9 ? 2'd2 : 2'd3;
                low = $urandom_range(0, 1) != 0 ? 12'($urandom_range(0, 40)) : 12'($urandom_range(4080, 4095));
                data_address = {10'($urandom), low};
                data_write = 16'($urandom);
                hold = $urandom_range(1, 12);
            end
            hold--;
            @(negedge clk);
        end
        command = 2'd0;
        repeat (30) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
